// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game sequencing logic.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Matches the ball's direction encoding.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int unsigned WIN_SCORE_DEF = 7;
  localparam int unsigned SCORE_W_DEF   = 4;

  // Bits needed to hold the larger of two frame counts.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the game controller and its surroundings.
interface pong_game_ctrl_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               i_frame_tick;
  logic               i_start;
  logic               i_miss_left;
  logic               i_miss_right;
  logic               o_ball_run;
  logic               o_ball_centre;
  logic               o_serve_dir;
  logic [SCORE_W-1:0] o_score1;
  logic [SCORE_W-1:0] o_score2;
  logic [2:0]         o_state;
  logic               o_game_over;

  modport master (
    output i_frame_tick, i_start, i_miss_left, i_miss_right,
    input  o_ball_run, o_ball_centre, o_serve_dir, o_score1, o_score2, o_state, o_game_over
  );

  modport slave (
    input  i_frame_tick, i_start, i_miss_left, i_miss_right,
    output o_ball_run, o_ball_centre, o_serve_dir, o_score1, o_score2, o_state, o_game_over
  );
endinterface

// File: rtl/pong_frame_timer.sv
// Loadable down-counter of frame ticks; flags the tick on which it runs out.
module pong_frame_timer #(
  parameter int unsigned TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] load_val,
  input  logic          load,
  input  logic          tick,
  output logic          expired_c
);

  logic [TW-1:0] cnt_q;

  // Load wins over a same-cycle tick; a zero load behaves as one frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (load_val == '0) ? TW'(1) : load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expired_c = tick && (cnt_q == TW'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Game sequencer: idle/serve/play/point/over phases, scores and ball control.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30,
  parameter int unsigned SCORE_W      = SCORE_W_DEF
) (
  input logic              i_clk,
  input logic              i_rst,
  pong_game_ctrl_if.slave  bus
);

  localparam int unsigned        TW       = timer_width(SERVE_FRAMES, POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [TW-1:0]      SERVE_LD = TW'(SERVE_FRAMES);
  localparam logic [TW-1:0]      POINT_LD = TW'(POINT_FRAMES);

  state_e             state_q, state_d;
  logic               start_q;
  logic               start_edge_c;
  logic               run_q, run_d;
  logic               centre_q, centre_d;
  logic               dir_q, dir_d;
  logic               over_q, over_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               tmr_load_c, tmr_tick_c, tmr_exp_c;
  logic [TW-1:0]      tmr_val_c;

  assign start_edge_c = bus.i_start & ~start_q;

  pong_frame_timer #(.TW(TW)) u_timer (
    .clk       (i_clk),
    .rst       (i_rst),
    .load_val  (tmr_val_c),
    .load      (tmr_load_c),
    .tick      (tmr_tick_c),
    .expired_c (tmr_exp_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      run_q    <= 1'b0;
      centre_q <= 1'b0;
      dir_q    <= DIR_RIGHT;
      over_q   <= 1'b0;
      score1_q <= '0;
      score2_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.i_start;
      run_q    <= run_d;
      centre_q <= centre_d;
      dir_q    <= dir_d;
      over_q   <= over_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    centre_d   = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = SERVE_LD;
    tmr_tick_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge_c) begin
          score1_d   = '0;
          score2_d   = '0;
          dir_d      = DIR_RIGHT;
          centre_d   = 1'b1;
          tmr_load_c = 1'b1;
          tmr_val_c  = SERVE_LD;
          state_d    = ST_SERVE;
        end
      end
      ST_SERVE: begin
        tmr_tick_c = bus.i_frame_tick;
        if (tmr_exp_c) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Simultaneous misses resolve to the left edge.
        if (bus.i_miss_left) begin
          score2_d   = (score2_q < WIN) ? score2_q + SCORE_W'(1) : score2_q;
          dir_d      = DIR_LEFT;
          tmr_load_c = 1'b1;
          tmr_val_c  = POINT_LD;
          state_d    = ST_POINT;
        end else if (bus.i_miss_right) begin
          score1_d   = (score1_q < WIN) ? score1_q + SCORE_W'(1) : score1_q;
          dir_d      = DIR_RIGHT;
          tmr_load_c = 1'b1;
          tmr_val_c  = POINT_LD;
          state_d    = ST_POINT;
        end
      end
      ST_POINT: begin
        tmr_tick_c = bus.i_frame_tick;
        if (tmr_exp_c) begin
          if ((score1_q == WIN) || (score2_q == WIN)) begin
            state_d = ST_OVER;
          end else begin
            centre_d   = 1'b1;
            tmr_load_c = 1'b1;
            tmr_val_c  = SERVE_LD;
            state_d    = ST_SERVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    run_d  = (state_d == ST_PLAY);
    over_d = (state_d == ST_OVER);
  end

  assign bus.o_ball_run    = run_q;
  assign bus.o_ball_centre = centre_q;
  assign bus.o_serve_dir   = dir_q;
  assign bus.o_score1      = score1_q;
  assign bus.o_score2      = score2_q;
  assign bus.o_state       = state_q;
  assign bus.o_game_over   = over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed, table-driven checks of the Pong game sequencer.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  typedef struct {
    string      name;
    logic       rst, start, ml, mr, tick;
    int         reps;
    logic [2:0] st;
    logic       run, cen, dir;
    logic [3:0] s1, s2;
    logic       over;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vq[$];
  logic [3:0] pdir;

  always #5 clk = ~clk;

  pong_game_ctrl_if #(.SCORE_W(4)) bus ();

  pong_game_ctrl #(
    .WIN_SCORE(7), .SERVE_FRAMES(60), .POINT_FRAMES(30), .SCORE_W(4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic add(input string n, input logic r, input logic s, input logic ml,
                     input logic mr, input logic t, input int reps, input logic [2:0] st,
                     input logic run, input logic cen, input logic dir,
                     input logic [3:0] s1, input logic [3:0] s2, input logic over);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.ml = ml; v.mr = mr; v.tick = t; v.reps = reps;
    v.st = st; v.run = run; v.cen = cen; v.dir = dir; v.s1 = s1; v.s2 = s2; v.over = over;
    vq.push_back(v);
  endtask

  task automatic cyc(input logic r, input logic s, input logic ml, input logic mr, input logic t);
    rst = r; bus.i_start = s; bus.i_miss_left = ml; bus.i_miss_right = mr; bus.i_frame_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [2:0] st, input logic run, input logic cen,
                       input logic dir, input logic [3:0] s1, input logic [3:0] s2, input logic over);
    logic [14:0] act, exp;
    act = {bus.o_state, bus.o_ball_run, bus.o_ball_centre, bus.o_serve_dir,
           bus.o_score1, bus.o_score2, bus.o_game_over};
    exp = {st, run, cen, dir, s1, s2, over};
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got st=%0d run=%b cen=%b dir=%b s1=%0d s2=%0d over=%b, want st=%0d run=%b cen=%b dir=%b s1=%0d s2=%0d over=%b",
               n, bus.o_state, bus.o_ball_run, bus.o_ball_centre, bus.o_serve_dir, bus.o_score1,
               bus.o_score2, bus.o_game_over, st, run, cen, dir, s1, s2, over);
    else
      n_pass++;
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_miss_left = 1'b0; bus.i_miss_right = 1'b0; bus.i_frame_tick = 1'b0;

    //   name            rst st ml mr tk reps  state     run cen dir s1 s2 over
    add("reset",          1, 0, 0, 0, 0, 2,  ST_IDLE,  0, 0, 0, 0, 0, 0);
    add("idle_miss",      0, 0, 1, 1, 0, 2,  ST_IDLE,  0, 0, 0, 0, 0, 0);
    add("idle_tick",      0, 0, 0, 0, 1, 3,  ST_IDLE,  0, 0, 0, 0, 0, 0);
    add("start",          0, 1, 0, 0, 0, 1,  ST_SERVE, 0, 1, 0, 0, 0, 0);
    add("start_held",     0, 1, 0, 0, 0, 3,  ST_SERVE, 0, 0, 0, 0, 0, 0);
    add("serve_miss",     0, 1, 1, 1, 0, 2,  ST_SERVE, 0, 0, 0, 0, 0, 0);
    add("serve_t59",      0, 0, 0, 0, 1, 59, ST_SERVE, 0, 0, 0, 0, 0, 0);
    add("serve_t60",      0, 0, 0, 0, 1, 1,  ST_PLAY,  1, 0, 0, 0, 0, 0);
    add("play_tick",      0, 0, 0, 0, 1, 4,  ST_PLAY,  1, 0, 0, 0, 0, 0);
    add("play_start",     0, 1, 0, 0, 0, 1,  ST_PLAY,  1, 0, 0, 0, 0, 0);
    add("miss_right",     0, 0, 0, 1, 0, 1,  ST_POINT, 0, 0, 0, 1, 0, 0);
    add("point_t29",      0, 0, 0, 0, 1, 29, ST_POINT, 0, 0, 0, 1, 0, 0);
    add("point_t30",      0, 0, 0, 0, 1, 1,  ST_SERVE, 0, 1, 0, 1, 0, 0);
    add("serve2_t60",     0, 0, 0, 0, 1, 60, ST_PLAY,  1, 0, 0, 1, 0, 0);
    add("miss_both",      0, 0, 1, 1, 0, 1,  ST_POINT, 0, 0, 1, 1, 1, 0);
    add("point_miss",     0, 0, 1, 0, 0, 3,  ST_POINT, 0, 0, 1, 1, 1, 0);
    add("point_start",    0, 1, 0, 0, 0, 1,  ST_POINT, 0, 0, 1, 1, 1, 0);
    add("point2_t30",     0, 0, 0, 0, 1, 30, ST_SERVE, 0, 1, 1, 1, 1, 0);
    pdir = 4'd1;
    for (int k = 2; k <= 7; k++) begin
      add("rally_serve",  0, 0, 0, 0, 1, 60, ST_PLAY,  1, 0, pdir[0], 4'(k - 1), 1, 0);
      add("rally_miss_r", 0, 0, 0, 1, 0, 1,  ST_POINT, 0, 0, 0, 4'(k), 1, 0);
      if (k < 7) add("rally_pt",  0, 0, 0, 0, 1, 30, ST_SERVE, 0, 1, 0, 4'(k), 1, 0);
      else       add("win_over",  0, 0, 0, 0, 1, 30, ST_OVER,  0, 0, 0, 7, 1, 1);
      pdir = 4'd0;
    end
    add("over_miss",      0, 0, 1, 1, 0, 3,  ST_OVER,  0, 0, 0, 7, 1, 1);
    add("over_tick",      0, 0, 0, 0, 1, 5,  ST_OVER,  0, 0, 0, 7, 1, 1);
    add("over_start",     0, 1, 0, 0, 0, 1,  ST_SERVE, 0, 1, 0, 0, 0, 0);
    add("g2_serve",       0, 0, 0, 0, 1, 60, ST_PLAY,  1, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 3; j++) begin
      add("g2_miss_l",    0, 0, 1, 0, 0, 1,  ST_POINT, 0, 0, 1, 0, 4'(j), 0);
      if (j < 3) begin
        add("g2_pt",      0, 0, 0, 0, 1, 30, ST_SERVE, 0, 1, 1, 0, 4'(j), 0);
        add("g2_sv",      0, 0, 0, 0, 1, 60, ST_PLAY,  1, 0, 1, 0, 4'(j), 0);
      end
    end
    add("mid_point",      0, 0, 0, 0, 1, 10, ST_POINT, 0, 0, 1, 0, 3, 0);
    add("mid_rst",        1, 1, 1, 0, 1, 1,  ST_IDLE,  0, 0, 0, 0, 0, 0);
    add("rst_release",    0, 1, 0, 0, 0, 1,  ST_SERVE, 0, 1, 0, 0, 0, 0);
    add("held_after_rst", 0, 1, 0, 0, 1, 5,  ST_SERVE, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      for (int k = 0; k < vq[i].reps; k++)
        cyc(vq[i].rst, vq[i].start, vq[i].ml, vq[i].mr, vq[i].tick);
      check(vq[i].name, vq[i].st, vq[i].run, vq[i].cen, vq[i].dir, vq[i].s1, vq[i].s2, vq[i].over);
    end

    // Tick coincident with the start edge must not count toward the serve timer.
    cyc(1, 0, 0, 0, 0);
    check("hs_reset", ST_IDLE, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    check("hs_start_tick", ST_SERVE, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("hs_centre_once", ST_SERVE, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 59; k++) cyc(0, 0, 0, 0, 1);
    check("hs_t59", ST_SERVE, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("hs_t60", ST_PLAY, 1, 0, 0, 0, 0, 0);
    // A two-cycle miss scores once and drops ball_run after one cycle.
    cyc(0, 0, 1, 0, 1);
    check("hs_miss_c1", ST_POINT, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    check("hs_miss_c2", ST_POINT, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
